// File: rtl/pipeline_ctrl_if.sv
// Cache handshake bundle between the pipeline sequencer and the I$/D$ ports.
// master = pipeline/cache side, slave = pipeline_ctrl.
interface pipeline_ctrl_if;
  logic imem_read;
  logic imem_resp;
  logic dmem_read;
  logic dmem_write;
  logic dmem_resp;
  logic imem_mask;
  logic dmem_mask;
  logic ibuf_load;
  logic dbuf_load;
  logic ibuf_sel;
  logic dbuf_sel;

  modport master (
    output imem_read, imem_resp, dmem_read, dmem_write, dmem_resp,
    input  imem_mask, dmem_mask, ibuf_load, dbuf_load, ibuf_sel, dbuf_sel
  );

  modport slave (
    input  imem_read, imem_resp, dmem_read, dmem_write, dmem_resp,
    output imem_mask, dmem_mask, ibuf_load, dbuf_load, ibuf_sel, dbuf_sel
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline. Holds the pipe while
// either cache is outstanding, remembers which side already responded so its
// data sits in a skid buffer, and resolves mispredict / load-use hazards on
// every advancing cycle. Saturating performance counters.
module pipeline_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  pipeline_ctrl_if.slave   cache,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_mem_read,
  input  logic             i_ex_mispredict,
  output logic             o_load_pc,
  output logic             o_pc_redirect,
  output logic             o_load_if_id,
  output logic             o_load_id_ex,
  output logic             o_load_ex_mem,
  output logic             o_load_mem_wb,
  output logic             o_flush_if_id,
  output logic             o_flush_id_ex,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt,
  output logic [CNT_W-1:0] o_bubble_cnt
);

  typedef enum logic {ST_RUN, ST_WAIT} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state, w_state_nxt;
  logic             r_i_done, r_d_done;
  logic             w_i_done_nxt, w_d_done_nxt;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt, r_bubble_cnt;
  logic             w_stall_inc, w_flush_inc, w_bubble_inc;
  logic             w_i_ok, w_d_ok, w_adv, w_load_use;
  logic             w_i_hit, w_d_hit, w_d_rd_hit;

  assign w_i_hit    = cache.imem_read & cache.imem_resp;
  assign w_d_hit    = (cache.dmem_read | cache.dmem_write) & cache.dmem_resp;
  assign w_d_rd_hit = cache.dmem_read & cache.dmem_resp;
  assign w_i_ok     = ~cache.imem_read | cache.imem_resp | r_i_done;
  assign w_d_ok     = ~(cache.dmem_read | cache.dmem_write) | cache.dmem_resp | r_d_done;
  assign w_adv      = w_i_ok & w_d_ok;
  assign w_load_use = i_ex_mem_read & (i_ex_rd != 5'd0) &
                      ((i_id_use_rs1 & (i_ex_rd == i_id_rs1)) |
                       (i_id_use_rs2 & (i_ex_rd == i_id_rs2)));

  // Next-state, completion flags, skid steering and hazard decode; all outputs forced low in reset.
  always_comb begin
    w_state_nxt     = r_state;
    w_i_done_nxt    = r_i_done;
    w_d_done_nxt    = r_d_done;
    w_stall_inc     = 1'b0;
    w_flush_inc     = 1'b0;
    w_bubble_inc    = 1'b0;
    o_load_pc       = 1'b0;
    o_pc_redirect   = 1'b0;
    o_load_if_id    = 1'b0;
    o_load_id_ex    = 1'b0;
    o_load_ex_mem   = 1'b0;
    o_load_mem_wb   = 1'b0;
    o_flush_if_id   = 1'b0;
    o_flush_id_ex   = 1'b0;
    cache.imem_mask = 1'b0;
    cache.dmem_mask = 1'b0;
    cache.ibuf_load = 1'b0;
    cache.dbuf_load = 1'b0;
    cache.ibuf_sel  = 1'b0;
    cache.dbuf_sel  = 1'b0;
    if (rst_n) begin
      unique case (r_state)
        ST_RUN: begin
          if (!w_adv) begin
            w_state_nxt     = ST_WAIT;
            w_i_done_nxt    = w_i_hit;
            w_d_done_nxt    = w_d_hit;
            cache.ibuf_load = w_i_hit;
            cache.dbuf_load = w_d_rd_hit;
          end
        end
        ST_WAIT: begin
          cache.imem_mask = r_i_done;
          cache.dmem_mask = r_d_done;
          cache.ibuf_load = w_i_hit & ~r_i_done;
          cache.dbuf_load = w_d_rd_hit & ~r_d_done;
          if (w_adv) begin
            cache.ibuf_sel = r_i_done;
            cache.dbuf_sel = r_d_done;
            w_i_done_nxt   = 1'b0;
            w_d_done_nxt   = 1'b0;
            w_state_nxt    = ST_RUN;
          end else begin
            if (w_i_hit) w_i_done_nxt = 1'b1;
            if (w_d_hit) w_d_done_nxt = 1'b1;
          end
        end
        default: w_state_nxt = ST_RUN;
      endcase

      if (!w_adv) begin
        w_stall_inc = 1'b1;
      end else if (i_ex_mispredict) begin
        o_load_pc     = 1'b1;
        o_pc_redirect = 1'b1;
        o_load_if_id  = 1'b1;
        o_load_id_ex  = 1'b1;
        o_load_ex_mem = 1'b1;
        o_load_mem_wb = 1'b1;
        o_flush_if_id = 1'b1;
        o_flush_id_ex = 1'b1;
        w_flush_inc   = 1'b1;
      end else if (w_load_use) begin
        o_load_id_ex  = 1'b1;
        o_flush_id_ex = 1'b1;
        o_load_ex_mem = 1'b1;
        o_load_mem_wb = 1'b1;
        w_bubble_inc  = 1'b1;
      end else begin
        o_load_pc     = 1'b1;
        o_load_if_id  = 1'b1;
        o_load_id_ex  = 1'b1;
        o_load_ex_mem = 1'b1;
        o_load_mem_wb = 1'b1;
      end
    end
  end

  // State, completion flags and saturating counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_RUN;
      r_i_done     <= 1'b0;
      r_d_done     <= 1'b0;
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_i_done <= w_i_done_nxt;
      r_d_done <= w_d_done_nxt;
      if (w_stall_inc && (r_stall_cnt != '1))   r_stall_cnt  <= r_stall_cnt + CNT_ONE;
      if (w_flush_inc && (r_flush_cnt != '1))   r_flush_cnt  <= r_flush_cnt + CNT_ONE;
      if (w_bubble_inc && (r_bubble_cnt != '1)) r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
    end
  end

  assign o_stall_cnt  = r_stall_cnt;
  assign o_flush_cnt  = r_flush_cnt;
  assign o_bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl (CNT_W=4 so saturation is reachable).
// Driver pushes hand-computed expectations; a negedge monitor pops and compares.
module tb_pipeline_ctrl;
  localparam int unsigned CW = 4;

  // input control word bits
  localparam logic [9:0] RN   = 10'h200;
  localparam logic [9:0] IR   = 10'h100;
  localparam logic [9:0] IRSP = 10'h080;
  localparam logic [9:0] DR   = 10'h040;
  localparam logic [9:0] DW   = 10'h020;
  localparam logic [9:0] DRSP = 10'h010;
  localparam logic [9:0] EXL  = 10'h008;
  localparam logic [9:0] MIS  = 10'h004;
  localparam logic [9:0] U1   = 10'h002;
  localparam logic [9:0] U2   = 10'h001;

  // expected output vector:
  // {load_pc,pc_redirect,if_id,id_ex,ex_mem,mem_wb,flush_if_id,flush_id_ex,
  //  imem_mask,dmem_mask,ibuf_load,dbuf_load,ibuf_sel,dbuf_sel}
  localparam logic [13:0] NONE = 14'h0000;
  localparam logic [13:0] NORM = 14'h2F00;
  localparam logic [13:0] MISP = 14'h3FC0;
  localparam logic [13:0] BUBB = 14'h0740;
  localparam logic [13:0] IM   = 14'h0020;
  localparam logic [13:0] IBL  = 14'h0008;
  localparam logic [13:0] DBL  = 14'h0004;
  localparam logic [13:0] IBS  = 14'h0002;

  typedef struct {
    string       nm;
    logic [13:0] o;
    logic [11:0] cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_use_rs1, id_use_rs2, ex_mem_read, ex_mispredict;
  logic load_pc, pc_redirect, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic flush_if_id, flush_id_ex;
  logic [CW-1:0] stall_cnt, flush_cnt, bubble_cnt;
  logic [13:0] act_o;

  exp_t sb[$];
  int unsigned n_tests;
  int unsigned n_fail;

  pipeline_ctrl_if u_if ();

  pipeline_ctrl #(.CNT_W(CW)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cache          (u_if),
    .i_id_rs1       (id_rs1),
    .i_id_rs2       (id_rs2),
    .i_id_use_rs1   (id_use_rs1),
    .i_id_use_rs2   (id_use_rs2),
    .i_ex_rd        (ex_rd),
    .i_ex_mem_read  (ex_mem_read),
    .i_ex_mispredict(ex_mispredict),
    .o_load_pc      (load_pc),
    .o_pc_redirect  (pc_redirect),
    .o_load_if_id   (load_if_id),
    .o_load_id_ex   (load_id_ex),
    .o_load_ex_mem  (load_ex_mem),
    .o_load_mem_wb  (load_mem_wb),
    .o_flush_if_id  (flush_if_id),
    .o_flush_id_ex  (flush_id_ex),
    .o_stall_cnt    (stall_cnt),
    .o_flush_cnt    (flush_cnt),
    .o_bubble_cnt   (bubble_cnt)
  );

  assign act_o = {load_pc, pc_redirect, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                  flush_if_id, flush_id_ex, u_if.imem_mask, u_if.dmem_mask,
                  u_if.ibuf_load, u_if.dbuf_load, u_if.ibuf_sel, u_if.dbuf_sel};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // monitor: compare combinational outputs and visible counters mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_tests++;
      if (act_o !== e.o) begin
        n_fail++;
        $display("FAIL %s outputs: got %014b expected %014b", e.nm, act_o, e.o);
      end
      n_tests++;
      if ({stall_cnt, flush_cnt, bubble_cnt} !== e.cnt) begin
        n_fail++;
        $display("FAIL %s counters(s,f,b): got %0d,%0d,%0d expected %0d,%0d,%0d", e.nm,
                 stall_cnt, flush_cnt, bubble_cnt, e.cnt[11:8], e.cnt[7:4], e.cnt[3:0]);
      end
    end
  end

  task automatic step(input string nm, input logic [9:0] c, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [4:0] rd, input logic [13:0] eo,
                      input int unsigned es, input int unsigned ef, input int unsigned eb);
    exp_t e;
    rst_n            = c[9];
    u_if.imem_read   = c[8];
    u_if.imem_resp   = c[7];
    u_if.dmem_read   = c[6];
    u_if.dmem_write  = c[5];
    u_if.dmem_resp   = c[4];
    ex_mem_read      = c[3];
    ex_mispredict    = c[2];
    id_use_rs1       = c[1];
    id_use_rs2       = c[0];
    id_rs1           = rs1;
    id_rs2           = rs2;
    ex_rd            = rd;
    e.nm  = nm;
    e.o   = eo;
    e.cnt = {es[3:0], ef[3:0], eb[3:0]};
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    u_if.imem_read = 1'b0; u_if.imem_resp = 1'b0;
    u_if.dmem_read = 1'b0; u_if.dmem_write = 1'b0; u_if.dmem_resp = 1'b0;
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0; ex_mispredict = 1'b0;
    @(posedge clk);
    #1;

    // reset: outputs held low even with active requests
    step("rst_idle", 10'h000, 0, 0, 0, NONE, 0, 0, 0);
    step("rst_busy", IR | IRSP | MIS | EXL, 0, 0, 0, NONE, 0, 0, 0);

    // 1: streaming fetch hits
    for (int i = 0; i < 10; i++)
      step("t1_stream", RN | IR | IRSP, 0, 0, 0, NORM, 0, 0, 0);

    // 2: imem responds first, dmem three cycles later
    step("t2_c1",  RN | IR | IRSP | DR, 0, 0, 0, IBL, 0, 0, 0);
    step("t2_c2",  RN | IR | DR, 0, 0, 0, IM, 1, 0, 0);
    step("t2_c3",  RN | IR | DR, 0, 0, 0, IM, 2, 0, 0);
    step("t2_rel", RN | IR | DR | DRSP, 0, 0, 0, NORM | IM | IBS | DBL, 3, 0, 0);
    step("t2_post", RN, 0, 0, 0, NORM, 3, 0, 0);

    // 3: load-use hazards
    step("t3_lu_rs2", RN | EXL | U2, 0, 5, 5, BUBB, 3, 0, 0);
    step("t3_rd0",    RN | EXL | U2, 0, 0, 0, NORM, 3, 0, 1);
    step("t3_lu_rs1", RN | EXL | U1, 7, 0, 7, BUBB, 3, 0, 1);
    step("t3_nouse",  RN | EXL, 7, 0, 7, NORM, 3, 0, 2);

    // 4: mispredict wins over load-use
    step("t4_mis_lu", RN | EXL | U2 | MIS, 0, 5, 5, MISP, 3, 0, 2);
    step("t4_post",   RN, 0, 0, 0, NORM, 3, 1, 2);

    // mispredict held through a stall acts only at release
    step("mis_stall", RN | IR | MIS, 0, 0, 0, NONE, 3, 1, 2);
    step("mis_rel",   RN | IR | IRSP | MIS, 0, 0, 0, MISP | IBL, 4, 1, 2);

    // simultaneous responses in RUN: no stall, no buffering
    step("dual_resp", RN | IR | IRSP | DR | DRSP, 0, 0, 0, NORM, 4, 2, 2);

    // store miss then release: no data buffer capture for writes
    step("st_stall", RN | DW, 0, 0, 0, NONE, 4, 2, 2);
    step("st_rel",   RN | DW | DRSP, 0, 0, 0, NORM, 5, 2, 2);

    // 5: stall counter saturation
    for (int k = 0; k < 14; k++)
      step("t5_sat", RN | IR, 0, 0, 0, NONE, ((5 + k) > 15) ? 15 : (5 + k), 2, 2);
    step("t5_rel",  RN | IR | IRSP, 0, 0, 0, NORM | IBL, 15, 2, 2);
    step("t5_hold", RN, 0, 0, 0, NORM, 15, 2, 2);

    // 6: reset while waiting with i_done set
    step("t6_c1",  RN | IR | IRSP | DR, 0, 0, 0, IBL, 15, 2, 2);
    step("t6_c2",  RN | IR | DR, 0, 0, 0, IM, 15, 2, 2);
    step("t6_rst", IR | DR, 0, 0, 0, NONE, 15, 2, 2);
    step("t6_after", RN | IR | DR, 0, 0, 0, NONE, 0, 0, 0);
    step("t6_rel", RN | IR | IRSP | DR | DRSP, 0, 0, 0, NORM | IBL | DBL, 1, 0, 0);
    step("t6_post", RN, 0, 0, 0, NORM, 1, 0, 0);

    for (int k = 0; k < 5 && sb.size() != 0; k++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
